// File: rtl/tdt_dmi_apb_master_pkg.sv
// Shared definitions for the DMI-to-APB master: op codes, FSM states and
// default sizing used by the top, its interface and the timeout counter.
package tdt_dmi_apb_master_pkg;

  localparam int unsigned DTM_ABITS_DEF      = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    DMI_OP_NOP = 2'b00,
    DMI_OP_RD  = 2'b01,
    DMI_OP_WR  = 2'b10
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10,
    ST_DONE   = 2'b11
  } dmi_state_e;

  // Only reads and writes touch the bus; 00 and 11 complete locally.
  function automatic logic is_apb_op(input logic [1:0] flg);
    return (flg == DMI_OP_RD) || (flg == DMI_OP_WR);
  endfunction

endpackage

// File: rtl/tdt_dmi_apb_master_if.sv
// DTM request/response handshake plus the APB3 bus of the DM-side master.
// master: the responder block; slave: the DTM/APB-slave side.
interface tdt_dmi_apb_master_if
  import tdt_dmi_apb_master_pkg::*;
#(
  parameter int unsigned DTM_ABITS   = DTM_ABITS_DEF,
  parameter int unsigned PADDR_WIDTH = DTM_ABITS + 2
);

  logic                   dtm_apbm_wr_vld;
  logic [DTM_ABITS-1:0]   dtm_apbm_wr_addr;
  logic [1:0]             dtm_apbm_wr_flg;
  logic [31:0]            dtm_apbm_wdata;
  logic [31:0]            apbm_dtm_rdata;
  logic                   apbm_dtm_wr_ready;
  logic                   apbm_dtm_err;

  logic [PADDR_WIDTH-1:0] paddr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            pwdata;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
    output apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output dtm_apbm_wr_vld, dtm_apbm_wr_addr, dtm_apbm_wr_flg, dtm_apbm_wdata,
    input  apbm_dtm_rdata, apbm_dtm_wr_ready, apbm_dtm_err,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/tdt_dmi_apb_timeout.sv
// ACCESS-phase watchdog for tdt_dmi_apb_master. Present only when
// TDT_DMI_APB_TIMEOUT_EN is defined. Saturating counter: cleared in SETUP,
// counts stalled ACCESS cycles, flags expiry at TIMEOUT_CYCLES-1.
`ifdef TDT_DMI_APB_TIMEOUT_EN
module tdt_dmi_apb_timeout
  import tdt_dmi_apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic tclk,
  input  logic trst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count stalled cycles, holding at LAST so the count never wraps.
  always_ff @(posedge tclk) begin
    if (trst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule
`endif

// File: rtl/tdt_dmi_apb_master.sv
// DM-side DMI responder: turns a one-cycle DTM request into one APB3
// transfer and answers with a one-cycle ready/err pulse plus read data.
// Optional ACCESS timeout: define TDT_DMI_APB_TIMEOUT_EN.
module tdt_dmi_apb_master
  import tdt_dmi_apb_master_pkg::*;
#(
  parameter int unsigned DTM_ABITS      = DTM_ABITS_DEF,
  parameter int unsigned PADDR_WIDTH    = DTM_ABITS + 2
`ifdef TDT_DMI_APB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                  tclk,
  input  logic                  trst,
  input  logic                  dmihardreset,
  tdt_dmi_apb_master_if.master  bus
);

  dmi_state_e           state_q;
  logic [DTM_ABITS-1:0] addr_q;
  logic [1:0]           op_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 psel_q;
  logic                 penable_q;
  logic                 ready_q;
  logic                 err_q;
  logic                 drop_q;
  logic                 tmo_expired;

`ifdef TDT_DMI_APB_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_clr = (state_q == ST_SETUP);
  assign tmo_en  = (state_q == ST_ACCESS) && !bus.pready;

  tdt_dmi_apb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .tclk      (tclk),
    .trst      (trst),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Request capture, APB sequencing and response generation.
  // A hard reset during SETUP/ACCESS cannot drop psel, so it only marks the
  // transfer as dropped; the transfer finishes and returns straight to IDLE.
  always_ff @(posedge tclk) begin
    if (trst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (dmihardreset) begin
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            drop_q  <= 1'b0;
          end else if (bus.dtm_apbm_wr_vld) begin
            addr_q  <= bus.dtm_apbm_wr_addr;
            op_q    <= bus.dtm_apbm_wr_flg;
            wdata_q <= bus.dtm_apbm_wdata;
            if (is_apb_op(bus.dtm_apbm_wr_flg)) begin
              state_q <= ST_SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              ready_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end

        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          if (dmihardreset) drop_q <= 1'b1;
        end

        ST_ACCESS: begin
          if (bus.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (drop_q || dmihardreset) begin
              state_q <= ST_IDLE;
              drop_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              ready_q <= 1'b1;
              err_q   <= bus.pslverr;
              if (op_q == DMI_OP_RD) rdata_q <= bus.prdata;
            end
          end else if (tmo_expired) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (drop_q || dmihardreset) begin
              state_q <= ST_IDLE;
              drop_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end else if (dmihardreset) begin
            drop_q <= 1'b1;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          if (dmihardreset) begin
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.psel              = psel_q;
  assign bus.penable           = penable_q;
  assign bus.pwrite            = psel_q & (op_q == DMI_OP_WR);
  assign bus.paddr             = psel_q ? PADDR_WIDTH'({addr_q, 2'b00}) : '0;
  assign bus.pwdata            = psel_q ? wdata_q : '0;
  assign bus.apbm_dtm_rdata    = rdata_q;
  assign bus.apbm_dtm_wr_ready = ready_q;
  assign bus.apbm_dtm_err      = err_q;

endmodule

// File: tb/tb_tdt_dmi_apb_master.sv
// Scoreboard bench for tdt_dmi_apb_master: the driver pushes expected APB
// transfers and DMI responses; an APB slave process and a response monitor
// pop and compare independently.
`timescale 1ns/1ps
module tb_tdt_dmi_apb_master;

  localparam int unsigned ABITS = 16;
  localparam int unsigned PAW   = ABITS + 2;
`ifdef TDT_DMI_APB_TIMEOUT_EN
  localparam int unsigned TMO   = 8;
`endif

  typedef struct {
    logic [PAW-1:0] paddr;
    logic           pwrite;
    logic [31:0]    pwdata;
    int unsigned    waits;
    int unsigned    len;
    logic [31:0]    prdata;
    logic           slverr;
  } apb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } rsp_exp_t;

  logic        tclk = 1'b0;
  logic        trst;
  logic        dmihardreset;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] held_rdata = '0;
  apb_exp_t    apb_q[$];
  rsp_exp_t    rsp_q[$];

  tdt_dmi_apb_master_if #(.DTM_ABITS(ABITS), .PADDR_WIDTH(PAW)) bus ();

  tdt_dmi_apb_master #(
    .DTM_ABITS      (ABITS),
    .PADDR_WIDTH    (PAW)
`ifdef TDT_DMI_APB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .tclk         (tclk),
    .trst         (trst),
    .dmihardreset (dmihardreset),
    .bus          (bus.master)
  );

  always #5 tclk = ~tclk;
  always @(posedge tclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  initial begin : monitor
    rsp_exp_t e;
    forever begin
      @(negedge tclk);
      if (!trst) begin
        if (bus.apbm_dtm_wr_ready) begin
          if (rsp_q.size() == 0) begin
            chk("ready_unexpected", 32'(bus.apbm_dtm_wr_ready), 32'd0);
          end else begin
            e = rsp_q.pop_front();
            chk("latency", cyc, e.due);
            chk("rdata", bus.apbm_dtm_rdata, e.rdata);
            chk("err", 32'(bus.apbm_dtm_err), 32'(e.err));
            held_rdata = e.rdata;
          end
        end else begin
          chk("err_without_ready", 32'(bus.apbm_dtm_err), 32'd0);
          chk("rdata_held", bus.apbm_dtm_rdata, held_rdata);
        end
      end
    end
  end

  // APB slave: checks each transfer against the expected queue and answers
  // with the planned wait states, read data and slave error.
  initial begin : apb_slave
    apb_exp_t    cur;
    bit          active;
    int unsigned acc;
    active      = 1'b0;
    acc         = 0;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    forever begin
      @(negedge tclk);
      if (trst) begin
        active     = 1'b0;
        bus.pready = 1'b0;
      end else if (bus.psel) begin
        if (!bus.penable) begin
          bus.pready = 1'b0;
          if (apb_q.size() == 0) begin
            chk("psel_unexpected", 32'(bus.psel), 32'd0);
            active = 1'b0;
          end else begin
            cur    = apb_q.pop_front();
            active = 1'b1;
            acc    = 0;
            chk("setup_paddr", 32'(bus.paddr), 32'(cur.paddr));
            chk("setup_pwrite", 32'(bus.pwrite), 32'(cur.pwrite));
            chk("setup_pwdata", bus.pwdata, cur.pwdata);
          end
        end else if (active) begin
          chk("access_paddr", 32'(bus.paddr), 32'(cur.paddr));
          chk("access_pwrite", 32'(bus.pwrite), 32'(cur.pwrite));
          chk("access_pwdata", bus.pwdata, cur.pwdata);
          if (acc == cur.waits) begin
            bus.pready  = 1'b1;
            bus.prdata  = cur.prdata;
            bus.pslverr = cur.slverr;
          end else begin
            bus.pready  = 1'b0;
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
          end
          acc++;
        end
      end else begin
        if (active) begin
          chk("psel_cycles", acc, cur.len);
          active = 1'b0;
        end
        chk("apb_idle_ctl", {30'd0, bus.penable, bus.pwrite}, 32'd0);
        chk("apb_idle_paddr", 32'(bus.paddr), 32'd0);
        chk("apb_idle_pwdata", bus.pwdata, 32'd0);
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        bus.prdata  = $urandom;
      end
    end
  end

  task automatic drive_req(input logic [1:0] flg, input logic [15:0] addr, input logic [31:0] wdata);
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = flg;
    bus.dtm_apbm_wr_addr = addr;
    bus.dtm_apbm_wdata   = wdata;
    @(posedge tclk); #1;
    bus.dtm_apbm_wr_vld  = 1'b0;
    bus.dtm_apbm_wr_flg  = 2'($urandom_range(0, 3));
    bus.dtm_apbm_wr_addr = 16'($urandom);
    bus.dtm_apbm_wdata   = $urandom;
  endtask

  task automatic wait_ready(input int unsigned budget);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge tclk);
      seen = bus.apbm_dtm_wr_ready;
    end
    if (!seen) chk("ready_timeout", 32'(bus.apbm_dtm_wr_ready), 32'd1);
    @(posedge tclk); #1;
  endtask

  // Model: reads return the slave data, writes keep the previous rdata,
  // no-ops return 0 after one cycle; bus ops take 3 + wait states.
  task automatic issue(input logic [1:0] flg, input logic [15:0] addr, input logic [31:0] wdata,
                       input int unsigned waits, input logic slverr, input logic [31:0] prd);
    apb_exp_t a;
    rsp_exp_t r;
    bit is_rd;
    bit is_wr;
    is_rd = (flg == 2'b01);
    is_wr = (flg == 2'b10);
    if (is_rd || is_wr) begin
      a.paddr  = {addr, 2'b00};
      a.pwrite = is_wr;
      a.pwdata = wdata;
      a.waits  = waits;
      a.len    = waits + 1;
      a.prdata = prd;
      a.slverr = slverr;
      apb_q.push_back(a);
      r.due   = cyc + 3 + waits;
      r.err   = slverr;
      r.rdata = is_rd ? prd : held_rdata;
    end else begin
      r.due   = cyc + 1;
      r.err   = 1'b0;
      r.rdata = '0;
    end
    rsp_q.push_back(r);
    drive_req(flg, addr, wdata);
    wait_ready(waits + 20);
  endtask

  task automatic wait_psel_low(input int unsigned budget);
    bit low;
    low = 1'b0;
    for (int unsigned i = 0; i < budget && !low; i++) begin
      @(negedge tclk);
      low = !bus.psel;
    end
    if (!low) chk("psel_release_timeout", 32'(bus.psel), 32'd0);
    @(posedge tclk); #1;
  endtask

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : driver
    apb_exp_t a;
    trst                 = 1'b1;
    dmihardreset         = 1'b0;
    bus.dtm_apbm_wr_vld  = 1'b0;
    bus.dtm_apbm_wr_flg  = '0;
    bus.dtm_apbm_wr_addr = '0;
    bus.dtm_apbm_wdata   = '0;
    repeat (3) @(posedge tclk);
    @(negedge tclk);
    chk("rst_ready", 32'(bus.apbm_dtm_wr_ready), 32'd0);
    chk("rst_err", 32'(bus.apbm_dtm_err), 32'd0);
    chk("rst_rdata", bus.apbm_dtm_rdata, 32'd0);
    chk("rst_psel", 32'(bus.psel), 32'd0);
    chk("rst_penable", 32'(bus.penable), 32'd0);
    chk("rst_pwrite", 32'(bus.pwrite), 32'd0);
    chk("rst_paddr", 32'(bus.paddr), 32'd0);
    chk("rst_pwdata", bus.pwdata, 32'd0);
    @(posedge tclk); #1;
    trst = 1'b0;
    @(posedge tclk); #1;

    // Directed cases.
    issue(2'b10, 16'h0010, 32'h8000_0001, 0, 1'b0, 32'h0);
    issue(2'b01, 16'h0011, 32'h0, 3, 1'b0, 32'h0000_0382);
    issue(2'b10, 16'h0012, 32'h1234_5678, 1, 1'b0, 32'h0);
    issue(2'b00, 16'h0013, 32'h0, 0, 1'b0, 32'h0);
    issue(2'b11, 16'hFFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'h0);
    issue(2'b10, 16'h0014, 32'hCAFE_0000, 0, 1'b1, 32'h0);
    issue(2'b01, 16'hFFFF, 32'h0, 2, 1'b1, 32'hA5A5_5A5A);

    // Hard reset in ACCESS: transfer completes silently, next read is clean.
    a.paddr  = {16'h0022, 2'b00};
    a.pwrite = 1'b0;
    a.pwdata = 32'h0;
    a.waits  = 3;
    a.len    = 4;
    a.prdata = 32'hDEAD_BEEF;
    a.slverr = 1'b0;
    apb_q.push_back(a);
    drive_req(2'b01, 16'h0022, 32'h0);
    @(posedge tclk); #1;
    dmihardreset = 1'b1;
    @(posedge tclk); #1;
    dmihardreset = 1'b0;
    wait_psel_low(20);
    issue(2'b01, 16'h0023, 32'h0, 0, 1'b0, 32'h0BAD_F00D);

    // Randomized traffic.
    for (int unsigned n = 0; n < 60; n++) begin
      issue(2'($urandom_range(0, 3)), 16'($urandom), $urandom,
            $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    // Hard reset in IDLE with a coinciding request: request dropped, rdata cleared.
    issue(2'b01, 16'h0030, 32'h0, 0, 1'b0, 32'h7777_0001);
    dmihardreset         = 1'b1;
    bus.dtm_apbm_wr_vld  = 1'b1;
    bus.dtm_apbm_wr_flg  = 2'b01;
    bus.dtm_apbm_wr_addr = 16'h0031;
    @(posedge tclk); #1;
    dmihardreset        = 1'b0;
    bus.dtm_apbm_wr_vld = 1'b0;
    held_rdata          = '0;
    repeat (4) @(posedge tclk);
    #1;
    issue(2'b10, 16'h0032, 32'h0000_00FF, 2, 1'b0, 32'h0);

`ifdef TDT_DMI_APB_TIMEOUT_EN
    begin : timeout_case
      rsp_exp_t r;
      a.paddr  = {16'h0040, 2'b00};
      a.pwrite = 1'b0;
      a.pwdata = 32'h0;
      a.waits  = 1000;
      a.len    = TMO;
      a.prdata = 32'h0;
      a.slverr = 1'b0;
      apb_q.push_back(a);
      r.due   = cyc + 2 + TMO;
      r.err   = 1'b1;
      r.rdata = '0;
      rsp_q.push_back(r);
      drive_req(2'b01, 16'h0040, 32'h0);
      wait_ready(TMO + 20);
    end
    issue(2'b01, 16'h0041, 32'h0, 1, 1'b0, 32'h1357_9BDF);
`endif

    repeat (5) @(posedge tclk);
    #1;
    chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    chk("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdt_dmi_apb_master.md
Name: tdt_dmi_apb_master

Overview:
- DM-side responder for DMI requests issued by the DTM instruction/data-register block.
- Accepts a one-cycle request pulse (address, op, wdata), runs one APB3 transfer to the debug-module register file, and returns a one-cycle completion pulse with read data.
- Sits in the TCLK domain between the DTM and the DM APB slave.

Parameters:
- DTM_ABITS, 16, DMI word-address width.
- PADDR_WIDTH, DTM_ABITS+2, APB byte-address width; paddr = {address, 2'b00}.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles before abort (used only with the optional feature).

Ports:
- tclk  in  1  sole clock.
- trst  in  1  synchronous active-high reset.
- dmihardreset  in  1  one-cycle DTM hard-reset pulse.
- dtm_apbm_wr_vld  in  1  request pulse.
- dtm_apbm_wr_addr  in  DTM_ABITS  DMI word address.
- dtm_apbm_wr_flg  in  2  op: 01 read, 10 write, 00/11 no-op.
- dtm_apbm_wdata  in  32  write data.
- apbm_dtm_rdata  out  32  read data; valid when ready pulses and held afterwards.
- apbm_dtm_wr_ready  out  1  one-cycle completion pulse.
- apbm_dtm_err  out  1  one-cycle error pulse, coincident with ready.
- paddr  out  PADDR_WIDTH  APB address.
- psel, penable, pwrite  out  1 each  APB control.
- pwdata  out  32  APB write data.
- prdata  in  32  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset is synchronous, active-high; applied on the tclk edge while trst=1. All outputs are 0 after reset; FSM = IDLE.
- Request capture:
  - In IDLE, dtm_apbm_wr_vld=1 registers addr, flg and wdata into holding registers.
  - vld outside IDLE is ignored; the DTM guarantees it does not occur.
- FSM states:
  - IDLE -> SETUP when vld with flg 01 or 10.
  - IDLE -> DONE when vld with flg 00 or 11. No APB activity; rdata is forced to 0.
  - SETUP: psel=1, penable=0, pwrite=(flg==10), paddr and pwdata driven from the holding registers. Always lasts 1 cycle, then ACCESS.
  - ACCESS: psel=1, penable=1. Stays while pready=0. When pready=1: capture prdata into rdata (reads only; writes leave rdata unchanged), capture pslverr, go to DONE.
  - DONE: apbm_dtm_wr_ready=1 for exactly 1 cycle, apbm_dtm_err=captured pslverr, then IDLE.
- Latency: vld to ready is 3 + N cycles, where N is the number of pready=0 cycles in ACCESS. A no-op takes 1 cycle (vld in cycle 0, ready in cycle 1).
- Address, pwrite and pwdata stay stable from SETUP through the end of ACCESS; they are 0 whenever psel=0.
- A new vld is accepted in the cycle after DONE (IDLE); back-to-back requests have no extra bubble.
- dmihardreset:
  - In IDLE or DONE: return to IDLE, clear the holding registers and rdata, suppress any pending ready pulse.
  - In SETUP or ACCESS: the APB transfer runs to completion (APB protocol forbids dropping psel). A drop-flag is set; the ready/err pulse is suppressed and rdata is not updated.
  - A vld coinciding with dmihardreset is dropped.
- trst in any state aborts immediately, psel included.
- Simultaneous pready and dmihardreset in ACCESS: the transfer completes, the response is dropped, and the FSM goes to IDLE.

Optional Feature:
- Macro: TDT_DMI_APB_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP and increments each ACCESS cycle with pready=0.
  - At TIMEOUT_CYCLES-1 without pready: drop psel/penable, go to DONE, rdata=32'h0, apbm_dtm_err=1 alongside ready.
  - The counter saturates and never wraps.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package/header tdt_dmi_define.h holds:
  - op encodings: DMI_OP_NOP=2'b00, DMI_OP_RD=2'b01, DMI_OP_WR=2'b10;
  - FSM state encodings: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, DONE=2'b11;
  - default TIMEOUT_CYCLES.
- One natural sub-module: tdt_dmi_apb_timeout (saturating counter with clear/enable and expiry output), instantiated only under the macro.

Test Plan:
- Write: vld, addr=16'h0010, flg=10, wdata=32'h8000_0001, pready=1 in the first ACCESS cycle -> psel high 2 cycles, paddr=18'h00040, pwrite=1, pwdata=32'h8000_0001; ready pulses in cycle 3; err=0.
- Read with 3 wait states: addr=16'h0011, flg=01, prdata=32'h0000_0382 -> ready in cycle 6, rdata=32'h0000_0382 held until the next read.
- No-op: flg=00 -> ready in cycle 1, psel never asserted, rdata=0.
- Hard reset mid-transfer: dmihardreset in ACCESS with pready held 0 for 2 more cycles -> psel stays until pready; no ready pulse; FSM returns to IDLE; a new read 1 cycle later completes normally.
- Slave error: write with pslverr=1 at pready -> ready and err both pulse for 1 cycle.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready stuck 0 -> psel drops after 8 ACCESS cycles; ready=1, err=1, rdata=0.
